// File: rtl/score_display_pkg.sv
// Shared geometry, state encoding and small helpers for the score digit display.
package score_display_pkg;

  localparam int DIGIT_W = 16;
  localparam int DIGIT_H = 32;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
  typedef logic [3:0] bcd_t;

  function automatic int pitch(input int spacing);
    return DIGIT_W + spacing;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Double-dabble correction applied before each shift.
  function automatic bcd_t add3(input bcd_t d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle,
// saturating to all nines when the score does not fit in NUM_DIGITS.
module bin2bcd_seq
  import score_display_pkg::*;
#(
  parameter int SCORE_W    = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    start,
  input  logic [SCORE_W-1:0]      score_in,
  output logic                    busy,
  output logic                    done_pulse,
  output logic [NUM_DIGITS*4-1:0] bcd_out
);

  localparam int              CW    = $clog2(SCORE_W + 1);
  localparam int              BW    = NUM_DIGITS * 4;
  localparam longint unsigned LIMIT = pow10(NUM_DIGITS);

  conv_state_t        state, next_state;
  logic [SCORE_W-1:0] shreg, score_q;
  logic [BW-1:0]      bcd_q, bcd_adj;
  logic [CW-1:0]      cnt;
  logic               last_shift, saturate;

  assign last_shift = (cnt == CW'(SCORE_W - 1));

  // NOTE: clocked blocks use <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last_shift) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    done_pulse = (state == DONE);
  end

  always_comb begin
    bcd_adj = '0;
    for (int k = 0; k < NUM_DIGITS; k++) bcd_adj[4*k +: 4] = add3(bcd_q[4*k +: 4]);
  end

  // NOTE: datapath registers are reset too, so bcd_out is never X before the first load.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shreg   <= '0;
      score_q <= '0;
      bcd_q   <= '0;
      cnt     <= '0;
    end else if (state == IDLE && start) begin
      shreg   <= score_in;
      score_q <= score_in;
      bcd_q   <= '0;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      bcd_q <= {bcd_adj[BW-2:0], shreg[SCORE_W-1]};
      shreg <= {shreg[SCORE_W-2:0], 1'b0};
      cnt   <= cnt + CW'(1);
    end
  end

  // Digits above NUM_DIGITS are dropped during shifting; saturation covers that case.
  assign saturate = (64'(score_q) >= LIMIT);
  assign bcd_out  = saturate ? {NUM_DIGITS{4'd9}} : bcd_q;

endmodule

// File: rtl/score_digits_driver.sv
// Score field driver: queues score conversions, commits results at frame start
// and maps each pixel to a digit cell for the downstream bitmap renderer.
module score_digits_driver
  import score_display_pkg::*;
#(
  parameter logic [10:0] TOP_LEFT_X    = 11'd16,
  parameter logic [10:0] TOP_LEFT_Y    = 11'd8,
  parameter int          NUM_DIGITS    = 4,
  parameter int          SCORE_W       = 14,
  parameter int          SPACING       = 2,
  parameter logic        BLANK_LEADING = 1'b1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic               startOfFrame,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic [3:0]         digit,
  output logic [10:0]        offsetX,
  output logic [10:0]        offsetY,
  output logic               InsideRectangle
);

  localparam int PITCH = pitch(SPACING);
  localparam int BW    = NUM_DIGITS * 4;

  logic               start, done_pulse;
  logic [BW-1:0]      result, pending_q, displayed_q;
  logic               pending_valid;
  logic [SCORE_W-1:0] req_score, start_score;
  logic               req_valid;

  // A fresh strobe outranks an older queued request: last write wins.
  assign start       = !busy && (score_valid || req_valid);
  assign start_score = score_valid ? score : req_score;

  bin2bcd_seq #(
    .SCORE_W    (SCORE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk        (clk),
    .resetN     (resetN),
    .start      (start),
    .score_in   (start_score),
    .busy       (busy),
    .done_pulse (done_pulse),
    .bcd_out    (result)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      req_score <= '0;
      req_valid <= 1'b0;
    end else if (score_valid && busy) begin
      req_score <= score;
      req_valid <= 1'b1;
    end else if (start) begin
      req_valid <= 1'b0;
    end
  end

  // A result finishing on the frame-start cycle waits for the following frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending_q     <= '0;
      pending_valid <= 1'b0;
      displayed_q   <= '0;
    end else begin
      if (startOfFrame && pending_valid) displayed_q <= pending_q;
      if (done_pulse) begin
        pending_q     <= result;
        pending_valid <= 1'b1;
      end else if (startOfFrame) begin
        pending_valid <= 1'b0;
      end
    end
  end

  int         px, py;
  logic       nxt_inside;
  logic [3:0] nxt_digit;
  logic [10:0] nxt_ox, nxt_oy;

  assign px = int'(pixelX);
  assign py = int'(pixelY);

  always_comb begin
    logic lz_run;
    logic in_rows;
    bcd_t d;
    nxt_inside = 1'b0;
    nxt_digit  = '0;
    nxt_ox     = '0;
    nxt_oy     = '0;
    lz_run     = 1'b1;
    d          = '0;
    in_rows    = (py >= int'(TOP_LEFT_Y)) && (py < int'(TOP_LEFT_Y) + DIGIT_H);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d      = displayed_q[4*(NUM_DIGITS-1-i) +: 4];
      lz_run = lz_run && (d == 4'd0);
      if (in_rows && px >= int'(TOP_LEFT_X) + i*PITCH
                  && px <  int'(TOP_LEFT_X) + i*PITCH + DIGIT_W) begin
        nxt_digit  = d;
        nxt_ox     = 11'(px - int'(TOP_LEFT_X) - i*PITCH);
        nxt_oy     = 11'(py - int'(TOP_LEFT_Y));
        nxt_inside = !(BLANK_LEADING && lz_run && (i != NUM_DIGITS - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      InsideRectangle <= 1'b0;
      digit           <= '0;
      offsetX         <= '0;
      offsetY         <= '0;
    end else begin
      InsideRectangle <= nxt_inside;
      digit           <= nxt_digit;
      offsetX         <= nxt_ox;
      offsetY         <= nxt_oy;
    end
  end

endmodule

// File: tb/tb_score_digits_driver.sv
// Bench for score_digits_driver: one instance with leading-zero blanking, one without.
module tb_score_digits_driver;

  localparam int N   = 4;
  localparam int SW  = 14;
  localparam int TLX = 16;
  localparam int TLY = 8;
  localparam int PIT = 18;

  logic          clk = 1'b0;
  logic          resetN;
  logic [10:0]   pixelX, pixelY;
  logic          startOfFrame, score_valid;
  logic [SW-1:0] score;

  logic        busy, ir, busy_nb, ir_nb;
  logic [3:0]  dg, dg_nb;
  logic [10:0] ox, oy, ox_nb, oy_nb;

  int vectors     = 0;
  int miscompares = 0;
  int model_val   = 0;

  typedef struct {
    int x, y, ins, dg, ox, oy;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  score_digits_driver dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .score(score), .score_valid(score_valid),
    .busy(busy), .digit(dg), .offsetX(ox), .offsetY(oy), .InsideRectangle(ir)
  );

  score_digits_driver #(.BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .score(score), .score_valid(score_valid),
    .busy(busy_nb), .digit(dg_nb), .offsetX(ox_nb), .offsetY(oy_nb), .InsideRectangle(ir_nb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int p10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Reference: which cell the pixel falls in and what the displayed number shows there.
  task automatic model_pix(input int x, input int y, input bit blank,
                           output int ins, output int d, output int oxe, output int oye);
    ins = 0; d = 0; oxe = 0; oye = 0;
    for (int i = 0; i < N; i++) begin
      int xl = TLX + i * PIT;
      if (x >= xl && x < xl + 16 && y >= TLY && y < TLY + 32) begin
        d   = (model_val / p10(N - 1 - i)) % 10;
        oxe = x - xl;
        oye = y - TLY;
        ins = (blank && i != N - 1 && model_val < p10(N - 1 - i)) ? 0 : 1;
      end
    end
  endtask

  task automatic check_pix(input string tag, input int x, input int y);
    int e_in, e_dg, e_ox, e_oy;
    pixelX = 11'(x);
    pixelY = 11'(y);
    tick();
    model_pix(x, y, 1'b1, e_in, e_dg, e_ox, e_oy);
    check({tag, ".inside"}, 32'(ir), e_in);
    check({tag, ".digit"},  32'(dg), e_dg);
    check({tag, ".offx"},   32'(ox), e_ox);
    check({tag, ".offy"},   32'(oy), e_oy);
    model_pix(x, y, 1'b0, e_in, e_dg, e_ox, e_oy);
    check({tag, ".nb.inside"}, 32'(ir_nb), e_in);
    check({tag, ".nb.digit"},  32'(dg_nb), e_dg);
    check({tag, ".nb.offx"},   32'(ox_nb), e_ox);
    check({tag, ".nb.offy"},   32'(oy_nb), e_oy);
  endtask

  task automatic check_cells(input string tag);
    for (int i = 0; i < N; i++) check_pix($sformatf("%s.cell%0d", tag, i), TLX + i * PIT + 3, TLY + 4);
  endtask

  task automatic load(input int s);
    score       = SW'(s);
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    check({tag, ".idle_reached"}, 32'(busy), 0);
  endtask

  initial begin
    tbl[0] = '{16, 8, 1, 1, 0, 0};
    tbl[1] = '{34, 8, 1, 2, 0, 0};
    tbl[2] = '{52, 8, 1, 3, 0, 0};
    tbl[3] = '{70, 8, 1, 4, 0, 0};
    tbl[4] = '{32, 8, 0, 0, 0, 0};
    tbl[5] = '{85, 39, 1, 4, 15, 31};
    tbl[6] = '{86, 20, 0, 0, 0, 0};
    tbl[7] = '{20, 40, 0, 0, 0, 0};
    tbl[8] = '{15, 10, 0, 0, 0, 0};
    tbl[9] = '{21, 7, 0, 0, 0, 0};

    resetN = 1'b0; pixelX = '0; pixelY = '0;
    startOfFrame = 1'b0; score_valid = 1'b0; score = '0;
    #12;
    check("reset.busy",    32'(busy),    0);
    check("reset.busy_nb", 32'(busy_nb), 0);
    check("reset.inside",  32'(ir),      0);
    check("reset.digit",   32'(dg),      0);
    check("reset.offx",    32'(ox),      0);
    check("reset.offy",    32'(oy),      0);
    @(negedge clk) resetN = 1'b1;
    tick();

    model_val = 0;
    check_pix("rst_cell3", TLX + 3 * PIT + 5, TLY + 10);
    check_pix("rst_cell0", TLX + 5, TLY + 10);

    // Busy window and no display change before frame start.
    load(1234);
    check("t1234.busy_first", 32'(busy), 1);
    tick(SW);
    check("t1234.busy_last", 32'(busy), 1);
    tick();
    check("t1234.busy_end", 32'(busy), 0);
    check_pix("t1234.precommit", TLX + 2, TLY + 2);
    frame();
    model_val = 1234;
    foreach (tbl[i]) begin
      pixelX = 11'(tbl[i].x);
      pixelY = 11'(tbl[i].y);
      tick();
      check($sformatf("tbl%0d.inside", i), 32'(ir), tbl[i].ins);
      check($sformatf("tbl%0d.digit", i),  32'(dg), tbl[i].dg);
      check($sformatf("tbl%0d.offx", i),   32'(ox), tbl[i].ox);
      check($sformatf("tbl%0d.offy", i),   32'(oy), tbl[i].oy);
      check($sformatf("tbl%0d.nb.inside", i), 32'(ir_nb), tbl[i].ins);
      check($sformatf("tbl%0d.nb.digit", i),  32'(dg_nb), tbl[i].dg);
    end

    load(12000);
    wait_idle("sat");
    frame();
    model_val = 9999;
    check_cells("sat");

    // Second load while busy: only the last one ends up on screen.
    load(42);
    tick(2);
    load(7);
    tick(2 * SW + 10);
    check("lastwins.busy", 32'(busy), 0);
    frame();
    model_val = 7;
    check_cells("lastwins");

    // Frame start between the two results shows 42 first.
    load(42);
    tick(2);
    load(7);
    tick(SW - 2);
    frame();
    model_val = 42;
    check_pix("between.cell3", TLX + 3 * PIT, TLY);
    check_pix("between.cell2", TLX + 2 * PIT, TLY);
    wait_idle("between");
    check_pix("between.hold", TLX + 3 * PIT + 1, TLY + 1);
    frame();
    model_val = 7;
    check_cells("between.after");

    // Result completing on the frame-start cycle waits one frame.
    load(55);
    tick(SW);
    frame();
    check_pix("doneSof.hold", TLX + 3 * PIT + 2, TLY + 3);
    frame();
    model_val = 55;
    check_cells("doneSof.next");

    // Reset in the middle of a conversion.
    load(500);
    tick(5);
    resetN = 1'b0;
    #1;
    check("midrst.busy",   32'(busy),   0);
    check("midrst.inside", 32'(ir),     0);
    #3 resetN = 1'b1;
    tick(SW + 5);
    check("midrst.busy_after", 32'(busy), 0);
    frame();
    model_val = 0;
    check_cells("midrst");

    load(5);
    wait_idle("five");
    frame();
    model_val = 5;
    check_cells("five");

    for (int it = 0; it < 20; it++) begin
      int s = int'($urandom_range(0, (1 << SW) - 1));
      load(s);
      wait_idle($sformatf("rnd%0d", it));
      frame();
      model_val = (s >= p10(N)) ? p10(N) - 1 : s;
      for (int j = 0; j < 6; j++)
        check_pix($sformatf("rnd%0d.s%0d.p%0d", it, s, j),
                  int'($urandom_range(0, 95)), int'($urandom_range(0, 45)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/score_digits_driver.md
# score_digits_driver

Drives the per-pixel digit interface of the numeric bitmap renderer for a multi-digit score field. A binary score is converted to BCD by a sequential shift-add-3 engine. The converted value is committed to the display only at frame start, so no mid-frame tearing is visible. Each cycle the block maps the current pixel to a digit cell and outputs digit, offsetX, offsetY and InsideRectangle to the renderer, which sits directly downstream.

## Interface
Parameters:
- TOP_LEFT_X, 11'd16: X of the left edge of the score field.
- TOP_LEFT_Y, 11'd8: Y of the top edge of the score field.
- NUM_DIGITS, 4: number of decimal digits. Legal range 1..5.
- SCORE_W, 14: width of the binary score input.
- SPACING, 2: blank columns between adjacent digit cells.
- BLANK_LEADING, 1'b1: 1 = suppress leading zeros. The least significant digit is always shown.

Ports:
- clk, input, 1: clock.
- resetN, input, 1: reset, asynchronous, active-low.
- pixelX, input, 11: current pixel column.
- pixelY, input, 11: current pixel row.
- startOfFrame, input, 1: one-cycle pulse at the start of each frame.
- score, input, SCORE_W: binary score, sampled when score_valid is high.
- score_valid, input, 1: one-cycle load strobe.
- busy, output, 1: high while a conversion is in progress.
- digit, output, 4: BCD digit to render for this pixel.
- offsetX, output, 11: X offset of the pixel within its digit cell.
- offsetY, output, 11: Y offset of the pixel within its digit cell.
- InsideRectangle, output, 1: pixel lies inside a visible digit cell.

## Operation
- Cell geometry: DIGIT_W = 16, DIGIT_H = 32, PITCH = DIGIT_W + SPACING.
  - Digit i, with 0 the most significant, occupies X in [TOP_LEFT_X + i·PITCH, TOP_LEFT_X + i·PITCH + DIGIT_W − 1] and Y in [TOP_LEFT_Y, TOP_LEFT_Y + DIGIT_H − 1].
  - Cell membership is found with NUM_DIGITS parallel constant-range compares. No divider.
- Conversion FSM:
  - IDLE: on score_valid, or when a request is pending, load the score into the shift register, clear the BCD register, go to SHIFT. busy = 1.
  - SHIFT: runs exactly SCORE_W cycles. Each cycle, first add 3 to every BCD nibble ≥ 5, then shift left by one, taking in the score MSB. After the last shift, go to DONE.
  - DONE: if the score was ≥ 10^NUM_DIGITS, set the result to all 9s (saturate). Write the result to the pending register, set pending_valid, go to IDLE.
- score_valid while busy: store the score in a one-deep request register; the last write wins. The request starts on the cycle after DONE. The active conversion is never aborted.
- Commit: on startOfFrame with pending_valid = 1, copy pending into the displayed register and clear pending_valid. If DONE and startOfFrame occur in the same cycle, the new result is not committed until the next frame.
- Blanking: when BLANK_LEADING = 1, any leading-zero digit except digit NUM_DIGITS−1 forces InsideRectangle = 0.
- Outside all cells, or in spacing columns: InsideRectangle = 0, digit = 0, offsets = 0.

## Timing
- Reset values:
  - busy = 0, InsideRectangle = 0, digit = 0, offsetX = 0, offsetY = 0.
  - Displayed, pending and request registers cleared; FSM in IDLE.
  - After reset the display shows "0", or "0000" when BLANK_LEADING = 0.
- Pixel path: registered, 1-cycle latency from pixelX/pixelY to all four pixel outputs. Together with the renderer's own register, total latency is 2 cycles.
- Conversion timing, with score_valid high in cycle t:
  - busy is high from t+1 through t+SCORE_W+1.
  - pending_valid rises at t+SCORE_W+2.
  - Minimum load-to-commit time is therefore SCORE_W+2 cycles plus the wait for the next startOfFrame.
- Reset mid-conversion: the conversion is abandoned, the FSM returns to IDLE, and the request register is cleared.

## Structure
- Shared package score_display_pkg holds:
  - DIGIT_W, DIGIT_H, the PITCH function;
  - typedef enum {IDLE, SHIFT, DONE} conv_state_t;
  - typedef logic [3:0] bcd_t.
- Sub-module bin2bcd_seq contains the FSM, shift register and saturation logic. Its interface is start / busy / done_pulse / bcd_out.
- The top level holds the request, pending and displayed registers plus the pixel-mapping register stage.

## Test plan
- Reset, then pixel (TOP_LEFT_X+3·18+5, TOP_LEFT_Y+10) → next cycle: InsideRectangle = 1, digit = 0, offsetX = 5, offsetY = 10. Digit 0 at the same row → InsideRectangle = 0 (blanked).
- Load score = 1234, then pulse startOfFrame after busy falls → digits 1, 2, 3, 4. Cells 0..3 at offset (0,0) return each digit. X = TOP_LEFT_X+16 (spacing column) → InsideRectangle = 0.
- Load score = 12000 (≥ 10^4) → the display reads 9999 after commit.
- Load 42, then load 7 while busy, then one startOfFrame after both finish → the display shows 7. With a startOfFrame between the two results, 42 is shown for that frame.
- Assert resetN = 0 at SHIFT cycle 6 of a conversion of 500 → busy = 0 and the display shows 0. No commit happens at the next frame.
- BLANK_LEADING = 0, score = 5 → digits 0, 0, 0, 5, all with InsideRectangle = 1.
